// File: rtl/cache_axi_refill.sv
// Cacheline refill engine: optional dirty-victim write-back burst followed by
// a line read burst over AXI4, then a one-cycle refresh pulse to the cache.
module cache_axi_refill #(
  parameter int LINE_WORDS  = 16,
  parameter int OFFSET_BITS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss,
  input  logic [31:0]             axi_raddr,
  input  logic                    write_back,
  input  logic [31:0]             axi_waddr,
  input  logic [32*LINE_WORDS-1:0] cacheline_old,
  output logic                    refresh,
  output logic [32*LINE_WORDS-1:0] cacheline_new,
  output logic                    busy,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [31:0]             rdata,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int LINE_W = 32 * LINE_WORDS;
  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int TAG_W  = 32 - OFFSET_BITS;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, DONE
  } state_t;

  state_t              state, state_nxt;
  logic [BEAT_W-1:0]   beat;
  logic [TAG_W-1:0]    raddr_q, waddr_q;
  logic [LINE_W-1:0]   old_q, line_q;
  logic                unused_ok;

  // Burst end is decided by the beat counter alone, so rlast and the
  // in-line offset bits of the request addresses are deliberately dropped.
  assign unused_ok = ^{rlast, axi_raddr[OFFSET_BITS-1:0], axi_waddr[OFFSET_BITS-1:0]};

  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign awlen   = 8'(LINE_WORDS - 1);
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign wstrb   = 4'hF;

  assign araddr        = {raddr_q, {OFFSET_BITS{1'b0}}};
  assign awaddr        = {waddr_q, {OFFSET_BITS{1'b0}}};
  assign wdata         = old_q[32*beat +: 32];
  assign cacheline_new = line_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    refresh   = 1'b0;
    busy      = (state != IDLE);
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    case (state)
      IDLE:  if (miss) state_nxt = write_back ? WB_AW : RD_AR;
      WB_AW: begin
        awvalid = 1'b1;
        if (awready) state_nxt = WB_W;
      end
      WB_W: begin
        wvalid = 1'b1;
        wlast  = (beat == LAST_BEAT);
        if (wready && wlast) state_nxt = WB_B;
      end
      WB_B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = RD_AR;
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RD_R;
      end
      RD_R: begin
        rready = 1'b1;
        if (rvalid && beat == LAST_BEAT) state_nxt = DONE;
      end
      DONE: begin
        refresh   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat <= '0;
    end else if ((state == WB_AW && awready) || (state == RD_AR && arready)) begin
      beat <= '0;
    end else if ((state == WB_W && wready) || (state == RD_R && rvalid)) begin
      beat <= beat + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raddr_q <= '0;
      waddr_q <= '0;
      old_q   <= '0;
      line_q  <= '0;
    end else begin
      if (state == IDLE && miss) begin
        raddr_q <= axi_raddr[31:OFFSET_BITS];
        waddr_q <= axi_waddr[31:OFFSET_BITS];
        old_q   <= cacheline_old;
      end
      if (state == RD_R && rvalid) line_q[32*beat +: 32] <= rdata;
    end
  end

endmodule

// File: tb/tb_cache_axi_refill.sv
// Directed bench for cache_axi_refill: the bench acts as the AXI slave and
// checks addresses, burst data, handshake stability, refresh and reset.
module tb_cache_axi_refill;

  localparam int LW = 16;
  localparam int OB = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            miss = 1'b0;
  logic [31:0]     axi_raddr = '0;
  logic            write_back = 1'b0;
  logic [31:0]     axi_waddr = '0;
  logic [32*LW-1:0] cacheline_old = '0;
  logic            refresh;
  logic [32*LW-1:0] cacheline_new;
  logic            busy;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready = 1'b0;
  logic [31:0]     rdata = '0;
  logic            rlast = 1'b0;
  logic            rvalid = 1'b0;
  logic            rready;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready = 1'b0;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready = 1'b0;
  logic            bvalid = 1'b0;
  logic            bready;

  cache_axi_refill #(.LINE_WORDS(LW), .OFFSET_BITS(OB)) dut (
    .clk(clk), .rst(rst), .miss(miss), .axi_raddr(axi_raddr),
    .write_back(write_back), .axi_waddr(axi_waddr), .cacheline_old(cacheline_old),
    .refresh(refresh), .cacheline_new(cacheline_new), .busy(busy),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int refresh_cnt = 0;
  int aw_cnt = 0;
  int w_cnt = 0;

  always @(negedge clk) begin
    if (refresh === 1'b1) refresh_cnt++;
    if (awvalid === 1'b1) aw_cnt++;
    if (wvalid === 1'b1) w_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, run did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    return cacheline_new[32*i +: 32];
  endfunction

  function automatic logic sel(input int which);
    case (which)
      0: return awvalid;
      1: return wvalid;
      2: return bready;
      3: return arvalid;
      default: return rready;
    endcase
  endfunction

  task automatic wait_hi(input int which, input string tag);
    int n = 0;
    while (sel(which) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, {31'b0, sel(which)}, 32'd1);
  endtask

  task automatic aw_phase(input bit bp, input logic [31:0] exp);
    wait_hi(0, "aw_wait");
    if (bp) begin
      for (int k = 0; k < 2; k++) begin
        check("aw_hold_valid", {31'b0, awvalid}, 32'd1);
        check("aw_hold_addr", awaddr, exp);
        @(negedge clk);
      end
    end
    check("awaddr", awaddr, exp);
    check("awlen", {24'b0, awlen}, 32'd15);
    check("awsize", {29'b0, awsize}, 32'd2);
    check("awburst", {30'b0, awburst}, 32'd1);
    check("aw_no_ar", {31'b0, arvalid}, 32'd0);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
  endtask

  task automatic w_phase(input bit bp, input logic [31:0] base);
    wait_hi(1, "w_wait");
    for (int i = 0; i < LW; i++) begin
      if (bp && $urandom_range(0, 1) == 1) begin
        wready = 1'b0;
        @(negedge clk);
        check("w_hold_valid", {31'b0, wvalid}, 32'd1);
        check("w_hold_data", wdata, 32'(base + i));
      end
      check("wvalid", {31'b0, wvalid}, 32'd1);
      check("wdata", wdata, 32'(base + i));
      check("wlast", {31'b0, wlast}, (i == LW - 1) ? 32'd1 : 32'd0);
      check("wstrb", {28'b0, wstrb}, 32'hF);
      check("w_no_ar", {31'b0, arvalid}, 32'd0);
      wready = 1'b1;
      @(negedge clk);
      wready = 1'b0;
    end
  endtask

  task automatic b_phase();
    wait_hi(2, "b_wait");
    for (int k = 0; k < 3; k++) begin
      check("b_ready", {31'b0, bready}, 32'd1);
      check("ar_before_b", {31'b0, arvalid}, 32'd0);
      @(negedge clk);
    end
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
  endtask

  task automatic ar_phase(input int delay, input logic [31:0] exp);
    wait_hi(3, "ar_wait");
    for (int k = 0; k < delay; k++) begin
      check("ar_hold_valid", {31'b0, arvalid}, 32'd1);
      check("ar_hold_addr", araddr, exp);
      @(negedge clk);
    end
    check("araddr", araddr, exp);
    check("arlen", {24'b0, arlen}, 32'd15);
    check("arsize", {29'b0, arsize}, 32'd2);
    check("arburst", {30'b0, arburst}, 32'd1);
    check("ar_no_aw", {31'b0, awvalid | wvalid}, 32'd0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
  endtask

  task automatic r_beats(input bit bp, input logic [31:0] base, input int n);
    wait_hi(4, "r_wait");
    for (int i = 0; i < n; i++) begin
      if (bp && $urandom_range(0, 1) == 1) begin
        rvalid = 1'b0;
        @(negedge clk);
        check("r_hold_ready", {31'b0, rready}, 32'd1);
        check("r_no_refresh", {31'b0, refresh}, 32'd0);
      end
      rvalid = 1'b1;
      rdata  = 32'(base + i);
      rlast  = (i == LW - 1);
      check("rready", {31'b0, rready}, 32'd1);
      @(negedge clk);
      rvalid = 1'b0;
      rlast  = 1'b0;
    end
  endtask

  task automatic finish_refill(input logic [31:0] base);
    check("refresh_hi", {31'b0, refresh}, 32'd1);
    check("busy_done", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("refresh_lo", {31'b0, refresh}, 32'd0);
    check("busy_idle", {31'b0, busy}, 32'd0);
    for (int i = 0; i < LW; i++) check("line_word", word_of(i), 32'(base + i));
  endtask

  initial begin
    int rc0;
    logic [32*LW-1:0] old;

    // Reset state, checked while reset is held before any clock edge.
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_refresh", {31'b0, refresh}, 32'd0);
    check("rst_valids", {28'b0, arvalid, awvalid, wvalid, wlast}, 32'd0);
    check("rst_readys", {30'b0, rready, bready}, 32'd0);
    check("rst_line_w0", word_of(0), 32'd0);
    check("rst_line_w15", word_of(15), 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_awaddr", awaddr, 32'd0);
    check("rst_arlen", {24'b0, arlen}, 32'd15);
    check("rst_wstrb", {28'b0, wstrb}, 32'hF);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Clean miss: unaligned address, arready after 2 cycles, rdata = i.
    miss = 1'b1; write_back = 1'b0;
    axi_raddr = 32'h1000_0044; axi_waddr = 32'hDEAD_BEEF;
    @(negedge clk);
    miss = 1'b0;
    check("clean_busy", {31'b0, busy}, 32'd1);
    ar_phase(2, 32'h1000_0040);
    r_beats(1'b0, 32'd0, LW);
    finish_refill(32'd0);
    check("clean_no_aw", 32'(aw_cnt), 32'd0);
    check("clean_no_w", 32'(w_cnt), 32'd0);
    check("clean_refresh_cnt", 32'(refresh_cnt), 32'd1);

    // Dirty miss: write-back of 0xA0+i, then read of 0x500+i.
    for (int i = 0; i < LW; i++) old[32*i +: 32] = 32'hA0 + 32'(i);
    miss = 1'b1; write_back = 1'b1;
    axi_raddr = 32'h3000_0080; axi_waddr = 32'h2000_0010; cacheline_old = old;
    @(negedge clk);
    miss = 1'b0; write_back = 1'b0; cacheline_old = '0;
    aw_phase(1'b0, 32'h2000_0000);
    w_phase(1'b0, 32'hA0);
    b_phase();
    ar_phase(0, 32'h3000_0080);
    check("line_stable_until_r", word_of(5), 32'd5);
    r_beats(1'b0, 32'h500, LW);
    finish_refill(32'h500);
    check("dirty_w_beats", 32'(w_cnt), 32'd16);
    check("dirty_refresh_cnt", 32'(refresh_cnt), 32'd2);

    // Backpressure on every channel.
    for (int i = 0; i < LW; i++) old[32*i +: 32] = 32'hC00 + 32'(i);
    miss = 1'b1; write_back = 1'b1;
    axi_raddr = 32'h3100_017C; axi_waddr = 32'h2100_003F; cacheline_old = old;
    @(negedge clk);
    miss = 1'b0; write_back = 1'b0;
    aw_phase(1'b1, 32'h2100_0000);
    w_phase(1'b1, 32'hC00);
    b_phase();
    ar_phase(3, 32'h3100_0140);
    r_beats(1'b1, 32'hD00, LW);
    finish_refill(32'hD00);
    check("bp_refresh_cnt", 32'(refresh_cnt), 32'd3);

    // Reset asserted while beat 7 of a read burst is on the bus.
    miss = 1'b1; axi_raddr = 32'h4000_0000;
    @(negedge clk);
    miss = 1'b0;
    ar_phase(0, 32'h4000_0000);
    r_beats(1'b0, 32'h700, 7);
    rc0 = refresh_cnt;
    rvalid = 1'b1; rdata = 32'h707;
    #1 rst = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_rready", {31'b0, rready}, 32'd0);
    check("midrst_refresh", {31'b0, refresh}, 32'd0);
    check("midrst_line_w0", word_of(0), 32'd0);
    check("midrst_araddr", araddr, 32'd0);
    check("midrst_arlen", {24'b0, arlen}, 32'd15);
    rvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_no_refresh", 32'(refresh_cnt), 32'(rc0));
    miss = 1'b1; axi_raddr = 32'h4000_1000;
    @(negedge clk);
    miss = 1'b0;
    ar_phase(1, 32'h4000_1000);
    r_beats(1'b0, 32'hE0, LW);
    finish_refill(32'hE0);

    // Back-to-back: miss held high across refresh; address changes while busy.
    rc0 = refresh_cnt;
    miss = 1'b1; write_back = 1'b0; axi_raddr = 32'h5000_0004;
    @(negedge clk);
    axi_raddr = 32'h6000_0000;
    ar_phase(0, 32'h5000_0000);
    r_beats(1'b0, 32'h500, LW);
    finish_refill(32'h500);
    check("b2b_gap_arvalid", {31'b0, arvalid}, 32'd0);
    @(negedge clk);
    check("b2b_arvalid", {31'b0, arvalid}, 32'd1);
    check("b2b_araddr", araddr, 32'h6000_0000);
    miss = 1'b0;
    ar_phase(0, 32'h6000_0000);
    r_beats(1'b0, 32'h600, LW);
    finish_refill(32'h600);
    check("b2b_refresh_cnt", 32'(refresh_cnt - rc0), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_axi_refill.md
CACHE_AXI_REFILL -- requirements
Module: cache_axi_refill

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 16, 32-bit words per cacheline (power of two, 2..16).
REQ-002 SHALL have parameter OFFSET_BITS, default 6, byte-offset width of a cacheline (log2(LINE_WORDS*4)).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port miss  input  1  tag stage requests a line refill.
REQ-006 SHALL have port axi_raddr  input  32  refill address, sampled at miss acceptance.
REQ-007 SHALL have port write_back  input  1  victim line is dirty, sampled with miss.
REQ-008 SHALL have port axi_waddr  input  32  victim line address, sampled with miss.
REQ-009 SHALL have port cacheline_old  input  32*LINE_WORDS  victim line data, sampled with miss.
REQ-010 SHALL have port refresh  output  1  one-cycle pulse: cacheline_new valid, tag/data may update.
REQ-011 SHALL have port cacheline_new  output  32*LINE_WORDS  refilled line; word i at bits [32*i+31:32*i].
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have AXI4 master read ports: araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1 (out), arready 1 (in); rdata 32, rlast 1, rvalid 1 (in), rready 1 (out).
REQ-014 SHALL have AXI4 master write ports: awaddr 32, awlen 8, awsize 3, awburst 2, awvalid 1 (out), awready 1 (in); wdata 32, wstrb 4, wlast 1, wvalid 1 (out), wready 1 (in); bvalid 1 (in), bready 1 (out).

Function
REQ-015 SHALL implement FSM states IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, DONE.
REQ-016 SHALL in IDLE with miss=1 latch axi_raddr, axi_waddr, cacheline_old, and go to WB_AW if write_back=1, else RD_AR.
REQ-017 SHALL ignore miss, write_back and all address/data inputs outside IDLE.
REQ-018 SHALL drive awaddr={axi_waddr[31:OFFSET_BITS], 0}, awlen=LINE_WORDS-1, awsize=3'b010, awburst=2'b01, awvalid=1 throughout WB_AW; on awready go to WB_W.
REQ-019 SHALL in WB_W drive wvalid=1, wstrb=4'hF, wdata=latched word[beat]; advance beat on wready; wlast=1 when beat=LINE_WORDS-1; after that handshake go to WB_B.
REQ-020 SHALL in WB_B drive bready=1; on bvalid go to RD_AR; bresp not checked.
REQ-021 SHALL drive araddr={axi_raddr[31:OFFSET_BITS], 0}, arlen=LINE_WORDS-1, arsize=3'b010, arburst=2'b01, arvalid=1 throughout RD_AR; on arready go to RD_R.
REQ-022 SHALL in RD_R drive rready=1; on each rvalid store rdata into cacheline_new word[beat], increment beat; after the beat LINE_WORDS-1 handshake go to DONE.
REQ-023 SHALL determine burst end by beat counter only; rlast value ignored.
REQ-024 SHALL in DONE assert refresh=1 for exactly one cycle and return to IDLE the next cycle.
REQ-025 SHALL hold cacheline_new stable from DONE until the first rdata beat of the next refill.
REQ-026 SHALL keep valid outputs asserted and their payload unchanged until the corresponding ready is seen (AXI stability rule).
REQ-027 SHALL never assert arvalid/awvalid/wvalid outside their own states; read and write bursts never overlap.
REQ-028 SHALL accept a new miss in IDLE at the earliest on the cycle after refresh; back-to-back refills lose no cycle beyond this.
REQ-029 SHALL reset beat counter to 0 on entry to WB_W and RD_R.

Reset
REQ-030 SHALL on rst=0, asynchronously: state=IDLE, refresh=0, busy=0, all valid/ready outputs 0, beat=0, cacheline_new=0, latched address/data=0.
REQ-031 SHALL on reset mid-burst abandon the transaction with no refresh pulse; the outstanding AXI burst is not completed.
REQ-032 SHALL drive constant fields (arlen, arsize, arburst, awlen, awsize, awburst, wstrb) at their fixed values regardless of reset.

Verification
REQ-033 SHALL cover clean miss: miss=1, write_back=0, axi_raddr=0x1000_0044, arready after 2 cycles, 16 beats rdata=i -> araddr=0x1000_0040, cacheline_new word i=i, single refresh pulse, no AW/W activity.
REQ-034 SHALL cover dirty miss: write_back=1, axi_waddr=0x2000_0010, cacheline_old word i=0xA0+i -> awaddr=0x2000_0000, 16 W beats 0xA0..0xAF, wlast on 16th only, AR issued only after bvalid.
REQ-035 SHALL cover backpressure: random rvalid/wready/arready/awready deassertion -> payloads stable while valid and not ready, correct data, exactly one refresh.
REQ-036 SHALL cover rst=0 asserted during RD_R beat 7 -> outputs at reset values immediately, no refresh; subsequent miss completes normally.
REQ-037 SHALL cover back-to-back misses: miss held high across refresh -> second AR issued 2 cycles after refresh, miss ignored while busy=1.
